// File: rtl/parity_arb.sv
// Round-robin arbiter sharing one byte-parity unit among four requesters.
// Optional expected-parity checker enabled by `define PARITY_ARB_CHECK_EN.
//
// state | meaning
// IDLE  | wait for a request, capture winner byte, pulse gnt
// CALC  | compute parity of captured byte, raise out_valid
// HOLD  | hold result until out_ready, then advance pointer
module parity_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_id,
    output logic               out_even,
    output logic               out_odd
`ifdef PARITY_ARB_CHECK_EN
    ,
    input  logic [NREQ-1:0]    exp_even,
    output logic               out_err,
    output logic [7:0]         err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        ptr_q;
    logic [DW-1:0]     byte_q;
    logic [1:0]        id_q;
    logic [NREQ-1:0]   gnt_q;
    logic              out_valid_q;
    logic [1:0]        out_id_q;
    logic              out_even_q;

    logic              win_found_d;
    logic [1:0]        win_id_d;
    logic [1:0]        cand_d;
    logic [DW-1:0]     win_byte_d;
    logic [1:0]        ptr_d;

    // Scan downward from the farthest offset so the nearest requester to ptr wins.
    always_comb begin
        win_found_d = 1'b0;
        win_id_d    = 2'd0;
        cand_d      = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_d = ptr_q + 2'(k);
            if (req[cand_d]) begin
                win_found_d = 1'b1;
                win_id_d    = cand_d;
            end
        end
    end

    assign win_byte_d = din[win_id_d*DW +: DW];
    assign ptr_d      = id_q + 2'd1;

`ifdef PARITY_ARB_CHECK_EN
    logic       exp_q;
    logic       out_err_q;
    logic [7:0] err_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            byte_q      <= '0;
            id_q        <= 2'd0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= 2'd0;
            out_even_q  <= 1'b0;
`ifdef PARITY_ARB_CHECK_EN
            exp_q       <= 1'b0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
`endif
        end else begin
            gnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        byte_q           <= win_byte_d;
                        id_q             <= win_id_d;
                        gnt_q[win_id_d]  <= 1'b1;
`ifdef PARITY_ARB_CHECK_EN
                        exp_q            <= exp_even[win_id_d];
`endif
                        state_q          <= CALC;
                    end
                end
                CALC: begin
                    out_even_q  <= ^byte_q;
                    out_id_q    <= id_q;
                    out_valid_q <= 1'b1;
`ifdef PARITY_ARB_CHECK_EN
                    out_err_q   <= (^byte_q) != exp_q;
`endif
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
`ifdef PARITY_ARB_CHECK_EN
                        if (out_err_q && err_cnt_q != 8'hFF)
                            err_cnt_q <= err_cnt_q + 8'd1;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_even  = out_even_q;
    // Derived from the same flop so the complement holds through reset.
    assign out_odd   = ~out_even_q;

`ifdef PARITY_ARB_CHECK_EN
    assign out_err = out_err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule
